ipf_feeder: RTL
===============

IPF_FEEDER -- requirements
Module: ipf_feeder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- go  in  1  run request; sampled only while busy=0.
- wsize_cfg  in  2  kernel size: 0 = 3x3 (18 weight words), 1 = 5x5 (25 weight words), 2-3 illegal.
- ngroup_cfg  in  4  number of weight groups, 1..15; 0 is illegal.
- stride_cfg  in  1  stride select, passed through.
- pad_cfg  in  2  RLPadding select, passed through.
- w_ren, w_addr  out  1, 6  weight memory read enable and address.
- w_rdata  in  64  weight memory data; synchronous read, 1-cycle latency.
- i_ren, i_addr  out  1, 3  input memory read enable and address.
- i_rdata  in  64  input memory data; 1-cycle latency.
- w_valid, w_data  out  1, 64  weight word to the IPF.
- i_valid, i_data  out  1, 64  input word to the IPF.
- ctrl  out  2  IPF command: 0 = END, 1 = START, 2 = HOLD.
- wgroup  out  4  current group index.
- Wsize, stride, RLPadding  out  2, 1, 2  latched config values.
- busy, done, err  out  1  run active; completion pulse; illegal-config pulse.

Function
REQ-003 The FSM SHALL have states IDLE, LOADW, INPUT and FINISH, plus a one-stage data-valid pipeline that matches the memory latency.
REQ-004 In IDLE with go=1 and a legal config, the block SHALL latch the config, set busy=1 and enter LOADW; edge E0 is the edge that samples go.
REQ-005 In IDLE with go=1 and an illegal config (wsize_cfg>1 or ngroup_cfg=0), the block SHALL pulse err=1 for one cycle, stay in IDLE and issue no reads.
REQ-006 go SHALL be ignored while busy=1.
REQ-007 In LOADW, the block SHALL assert w_ren with w_addr = 0..WN-1 in cycles 1..WN after E0, where WN is 18 or 25.
REQ-008 w_valid SHALL be 1 in cycles 2..WN+1, with w_data = w_rdata, so the word at address k appears in cycle k+2.
REQ-009 In INPUT, for each group g = 0..G-1, the block SHALL read i_addr 0..7 on consecutive cycles with no bubble after LOADW or between groups.
REQ-010 i_valid SHALL be 1 in cycles WN+2 .. WN+1+8G.
REQ-011 On the data stage of each group, ctrl SHALL be 2 (HOLD) for words 0-1 and 1 (START) for words 2-7.
REQ-012 On the data stage of each group, wgroup SHALL equal g for all 8 words of that group.
REQ-013 ctrl SHALL be 2 during the weight phase and while idle.
REQ-014 In cycle WN+2+8G, the block SHALL drive ctrl=0 for exactly one cycle, pulse done=1 and clear busy (FINISH), then return to IDLE.
REQ-015 A go that is high in the cycle done=1 SHALL be accepted on the next edge.
REQ-016 w_valid and i_valid SHALL never be asserted in the same cycle.
REQ-017 Address counters SHALL restart at 0 per phase and per group and SHALL never exceed WN-1 or 7.
REQ-018 The outputs Wsize, stride and RLPadding SHALL hold the latched values from E0 until the next accepted go.
REQ-019 Changes on wsize_cfg, ngroup_cfg, stride_cfg or pad_cfg during a run SHALL have no effect on the run in progress.
REQ-020 w_data and i_data SHALL be 0 whenever the corresponding valid signal is 0.

Reset
REQ-021 While rst=0 at an edge, the block SHALL enter IDLE and clear all counters and the valid pipeline.
REQ-022 The output values under reset SHALL be: busy=0, done=0, err=0, w_valid=0, i_valid=0, w_ren=0, i_ren=0, all addresses and data = 0, wgroup=0, ctrl=2, Wsize=0, stride=0, RLPadding=0.
REQ-023 A reset mid-run SHALL abort the run with no done and no END, and a subsequent go SHALL restart from w_addr=0.

Verification
REQ-024 Case 3x3, G=2: w_valid in cycles 2-19 with w_addr 0..17 in cycles 1-18; i_valid in cycles 20-35 with i_addr sequence 0..7 twice; ctrl per group is 2,2,1,1,1,1,1,1; wgroup is 0 then 1; ctrl=0 and done=1 in cycle 36.
REQ-025 Case 5x5, G=1: w_valid for 25 cycles (2-26), then i_valid for 8 cycles (27-34); done=1 in cycle 35.
REQ-026 Case illegal config: go with ngroup_cfg=0 gives err=1 in the following cycle, busy=0 and no ren; go with wsize_cfg=3 gives the same response.
REQ-027 Case go while busy: a go pulse in cycle 10 of a run leaves the run length unchanged; go held high through done starts a second run whose w_addr=0 appears one cycle after done.
REQ-028 Case reset mid-run: rst=0 in cycle 8 of the weight phase gives all valids 0, ctrl=2 and busy=0 in the next cycle; a new go then reproduces the REQ-024 timing exactly.
REQ-029 Case data check: with the memories preloaded with address-tagged words, every w_data/i_data word equals mem[addr], and w_data/i_data are 0 whenever not valid.

Source files
------------

// File: rtl/ipf_feeder.sv
// Feeds weight and input words from two synchronous-read memories to the IPF,
// generating read addresses, a matched valid pipeline and the IPF command stream.
module ipf_feeder (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic [1:0]  wsize_cfg,
   input  logic [3:0]  ngroup_cfg,
   input  logic        stride_cfg,
   input  logic [1:0]  pad_cfg,
   output logic        w_ren,
   output logic [5:0]  w_addr,
   input  logic [63:0] w_rdata,
   output logic        i_ren,
   output logic [2:0]  i_addr,
   input  logic [63:0] i_rdata,
   output logic        w_valid,
   output logic [63:0] w_data,
   output logic        i_valid,
   output logic [63:0] i_data,
   output logic [1:0]  ctrl,
   output logic [3:0]  wgroup,
   output logic [1:0]  Wsize,
   output logic        stride,
   output logic [1:0]  RLPadding,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, LOADW, INPUT, FINISH} state_t;

   localparam logic [1:0] CTRL_END   = 2'd0;
   localparam logic [1:0] CTRL_START = 2'd1;
   localparam logic [1:0] CTRL_HOLD  = 2'd2;

   state_t      r_state;
   logic        r_wren;
   logic [5:0]  r_waddr;
   logic        r_iren;
   logic [2:0]  r_iaddr;
   logic [3:0]  r_grp;
   logic [3:0]  r_ngroup;
   logic [1:0]  r_wsize;
   logic        r_stride;
   logic [1:0]  r_pad;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic        r_wvalid;
   logic        r_ivalid;
   logic [1:0]  r_ctrl;
   logic [3:0]  r_wgroup;

   logic        w_cfgLegal;
   logic [5:0]  w_wordLast;

   assign w_cfgLegal = (wsize_cfg < 2'd2) && (ngroup_cfg != 4'd0);
   assign w_wordLast = (r_wsize == 2'd0) ? 6'd17 : 6'd24;

   // Sequencer: read requests are issued back-to-back from the weight phase
   // straight into the input groups, then one drain cycle before completion.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_wren   <= 1'b0;
         r_waddr  <= '0;
         r_iren   <= 1'b0;
         r_iaddr  <= '0;
         r_grp    <= '0;
         r_ngroup <= '0;
         r_wsize  <= '0;
         r_stride <= 1'b0;
         r_pad    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (go) begin
                  if (w_cfgLegal) begin
                     r_wsize  <= wsize_cfg;
                     r_ngroup <= ngroup_cfg;
                     r_stride <= stride_cfg;
                     r_pad    <= pad_cfg;
                     r_busy   <= 1'b1;
                     r_wren   <= 1'b1;
                     r_waddr  <= '0;
                     r_state  <= LOADW;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            LOADW: begin
               if (r_waddr == w_wordLast) begin
                  r_wren  <= 1'b0;
                  r_waddr <= '0;
                  r_iren  <= 1'b1;
                  r_iaddr <= '0;
                  r_grp   <= '0;
                  r_state <= INPUT;
               end else begin
                  r_waddr <= r_waddr + 6'd1;
               end
            end
            INPUT: begin
               r_iaddr <= r_iaddr + 3'd1;
               if (r_iaddr == 3'd7) begin
                  if (r_grp == r_ngroup - 4'd1) begin
                     r_iren  <= 1'b0;
                     r_grp   <= '0;
                     r_state <= FINISH;
                  end else begin
                     r_grp <= r_grp + 4'd1;
                  end
               end
            end
            FINISH: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Data stage: valids, command and group tag trail the read request by one
   // cycle so they line up with the memory's registered read data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wvalid <= 1'b0;
         r_ivalid <= 1'b0;
         r_ctrl   <= CTRL_HOLD;
         r_wgroup <= '0;
      end else begin
         r_wvalid <= r_wren;
         r_ivalid <= r_iren;
         if (r_state == FINISH) begin
            r_ctrl <= CTRL_END;
         end else if (r_iren) begin
            r_ctrl <= (r_iaddr < 3'd2) ? CTRL_HOLD : CTRL_START;
         end else begin
            r_ctrl <= CTRL_HOLD;
         end
         if (r_iren) begin
            r_wgroup <= r_grp;
         end
      end
   end

   assign w_ren     = r_wren;
   assign w_addr    = r_waddr;
   assign i_ren     = r_iren;
   assign i_addr    = r_iaddr;
   assign w_valid   = r_wvalid;
   assign w_data    = r_wvalid ? w_rdata : 64'd0;
   assign i_valid   = r_ivalid;
   assign i_data    = r_ivalid ? i_rdata : 64'd0;
   assign ctrl      = r_ctrl;
   assign wgroup    = r_wgroup;
   assign Wsize     = r_wsize;
   assign stride    = r_stride;
   assign RLPadding = r_pad;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule
